// File: rtl/gear_carry_resolver.sv
// GeAr approximate adder with a sequential carry-repair walk.
// One cycle gives the approximate sum; exact mode then repairs one sub-adder window per cycle.
module gear_carry_resolver #(
    parameter  int N  = 16,
    parameter  int R  = 4,
    parameter  int P  = 4,
    localparam int K  = (N - P) / R,
    localparam int CW = $clog2(K)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         exact,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic [K-2:0] err_mask,
    output logic [CW-1:0] err_cnt
);

    if (((N - P) % R) != 0 || K < 2 || P < 1) begin : g_bad_config
        $error("gear_carry_resolver: illegal N/R/P combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WALK, S_DONE} state_t;

    state_t        r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_exact;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic [K-2:0]  r_errMask;
    logic [CW-1:0] r_errCnt;
    logic [K-2:0]  r_gg;
    logic [K-2:0]  r_pg;
    logic [K-1:1]  r_op;
    logic          r_cr;
    logic [CW-1:0] r_k;

    logic [N-1:0]  w_approxSum;
    logic          w_approxCout;
    logic [R+P:0]  w_winSum;
    logic [K-2:0]  w_gg;
    logic [K-2:0]  w_pg;
    logic [K-1:1]  w_op;
    logic          w_gAcc;
    logic          w_pAcc;

    // Every window adds with carry-in 0; only window 0 keeps its overlap bits.
    always_comb begin
        w_approxSum  = '0;
        w_approxCout = 1'b0;
        w_winSum     = '0;
        w_gg         = '0;
        w_pg         = '0;
        w_op         = '0;
        w_gAcc       = 1'b0;
        w_pAcc       = 1'b1;
        for (int k = 0; k < K; k++) begin
            w_winSum = {1'b0, r_a[k*R +: R+P]} + {1'b0, r_b[k*R +: R+P]};
            if (k == 0)
                w_approxSum[R+P-1:0] = w_winSum[R+P-1:0];
            else
                w_approxSum[k*R+P +: R] = w_winSum[R+P-1:P];
            if (k == K - 1)
                w_approxCout = w_winSum[R+P];
        end
        for (int j = 0; j < K - 1; j++) begin
            w_gAcc = 1'b0;
            w_pAcc = 1'b1;
            for (int i = 0; i < R; i++) begin
                w_gAcc = (r_a[j*R+i] & r_b[j*R+i]) | ((r_a[j*R+i] ^ r_b[j*R+i]) & w_gAcc);
                w_pAcc = w_pAcc & (r_a[j*R+i] ^ r_b[j*R+i]);
            end
            w_gg[j] = w_gAcc;
            w_pg[j] = w_pAcc;
        end
        for (int k = 1; k < K; k++)
            w_op[k] = &(r_a[k*R +: P] ^ r_b[k*R +: P]);
    end

    logic          w_gSel;
    logic          w_pSel;
    logic          w_opSel;
    logic [R-1:0]  w_winSel;
    logic [R-1:0]  w_winInc;
    logic          w_c;
    logic          w_fix;
    logic          w_last;

    always_comb begin
        w_gSel   = 1'b0;
        w_pSel   = 1'b0;
        w_opSel  = 1'b0;
        w_winSel = '0;
        for (int i = 1; i < K; i++) begin
            if (r_k == CW'(i)) begin
                w_gSel   = r_gg[i-1];
                w_pSel   = r_pg[i-1];
                w_opSel  = r_op[i];
                w_winSel = r_sum[i*R+P +: R];
            end
        end
    end

    // A window mispredicts only when the true carry reaches it through a fully propagating overlap.
    assign w_c      = w_gSel | (w_pSel & r_cr);
    assign w_fix    = w_c & w_opSel;
    assign w_winInc = w_winSel + 1'b1;
    assign w_last   = (r_k == CW'(K - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_exact   <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_errMask <= '0;
            r_errCnt  <= '0;
            r_gg      <= '0;
            r_pg      <= '0;
            r_op      <= '0;
            r_cr      <= 1'b0;
            r_k       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_exact <= exact;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_sum     <= w_approxSum;
                    r_cout    <= w_approxCout;
                    r_gg      <= w_gg;
                    r_pg      <= w_pg;
                    r_op      <= w_op;
                    r_errMask <= '0;
                    r_errCnt  <= '0;
                    r_cr      <= 1'b0;
                    r_k       <= CW'(1);
                    r_state   <= r_exact ? S_WALK : S_DONE;
                end
                S_WALK: begin
                    if (w_fix) begin
                        for (int i = 1; i < K; i++) begin
                            if (r_k == CW'(i)) begin
                                r_sum[i*R+P +: R] <= w_winInc;
                                r_errMask[i-1]    <= 1'b1;
                            end
                        end
                        r_errCnt <= r_errCnt + 1'b1;
                        if (w_last && (w_winInc == '0))
                            r_cout <= 1'b1;
                    end
                    r_cr <= w_c;
                    r_k  <= r_k + 1'b1;
                    if (w_last)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign err_mask  = r_errMask;
    assign err_cnt   = r_errCnt;

endmodule
